// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : operand/result width used when none is given
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the bit-serial subtractor.
//   start, a, b, bin : request side, driven by the master
//   busy, done       : progress flags, driven by the slave
//   diff, bout       : registered result, driven by the slave
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: x - y - bi.
//   x, y, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of serial_subtractor_if (start/a/b/bin in,
//              busy/done/diff/bout out)
// A start in IDLE or DONE captures the operands; WIDTH RUN cycles follow,
// then a one-cycle done pulse with diff/bout already registered.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    // Only the upper WIDTH-1 accumulated bits are ever needed again: the
    // bit that would land in position 0 falls out on the final shift.
    logic [WIDTH-2:0]   sacc;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;

    logic               d;
    logic               nb;
    logic [WIDTH-1:0]   sacc_next;
    logic               last_bit;
    logic               load;

    full_subtractor_bit u_cell (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (d),
        .bo (nb)
    );

    assign sacc_next = {d, sacc};
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign load      = bus.start && (state == IDLE || state == DONE);

    // NOTE: state updates use non-blocking assignments so every flop samples
    // values from before the edge, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sacc   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (load) begin
            sa   <= bus.a;
            sb   <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
            sacc <= '0;
        end else if (state == RUN) begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            sacc <= sacc_next[WIDTH-1:1];
            br   <= nb;
            if (last_bit) begin
                // Counter parks at zero rather than running past WIDTH-1.
                cnt    <= '0;
                diff_q <= sacc_next;
                bout_q <= nb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes diff = a − b − bin, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flop.
- It is the counterpart to the team's full-adder blocks: it performs the inverse arithmetic through a start/busy/done handshake.
- It trades latency for area in datapaths where a parallel subtractor is too large.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on the rising edge when accepted
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff/bout are valid from this cycle on
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH
- bout  output  1  final borrow-out; 1 iff a < b + bin, unsigned

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Shift registers, borrow flop and bit counter are cleared.
  - Reset wins over every other event, including mid-RUN. The in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load sa←a, sb←b, br←bin, cnt←0, sacc←0, go to RUN.
- RUN (busy=1):
  - Each edge computes on bit 0: d = sa[0]^sb[0]^br; nb = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Shift sa and sb right by 1.
  - Shift d into the MSB of sacc (right-shift accumulate).
  - br←nb, cnt←cnt+1.
  - On the edge where cnt==WIDTH−1:
    - diff←{d, sacc[WIDTH−1:1]}, bout←nb.
    - Go to DONE.
  - start is ignored in RUN. Operands already captured are not disturbed by changes on a/b/bin.
- DONE:
  - done=1, busy=0, for exactly one cycle.
  - Next edge: if start=1, load a new operation as in IDLE and go to RUN (back-to-back accepted). Otherwise go to IDLE.
- Latency:
  - Start accepted at edge E0.
  - done is high in the cycle following edge E0+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- Output holding:
  - diff and bout are registered.
  - They change only on completion or reset, and hold their value through IDLE and the next RUN.
- Widths:
  - cnt is $clog2(WIDTH) bits and never wraps past WIDTH−1.
  - Result wraps modulo 2^WIDTH; underflow is reported only through bout.
- Simultaneous start and rst: rst wins; no operation is started.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default WIDTH constant
- Sub-module full_subtractor_bit: purely combinational. Inputs x, y, bi; outputs d, bo. Instantiated once in the datapath.
- FSM, counter and shift registers live in the top module.

Test Plan:
- Reset then idle → busy=0, done=0, diff=0x00, bout=0. start held low for 20 cycles → no done pulse.
- a=0x05, b=0x03, bin=0, start 1 cycle → busy for 8 cycles, done pulse 8 edges after the accepting edge, diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then back-to-back start asserted during DONE with a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0 after 8 more cycles.
- a=0x80, b=0x01 started; mid-RUN, a/b changed and start pulsed at cycle 3 → ignored, result diff=0x7F, bout=0, exactly one done pulse.
- a=0x10, b=0x01 started; rst asserted asynchronously at cycle 4 → busy=0, diff=0, bout=0 immediately, no done pulse. After release, new op a=0x0A, b=0x0A → diff=0x00, bout=0.
